// File: rtl/telemetry_framer.sv
// telemetry_framer
//
// Packetiser between the rail-sensor sampler and the UART transmitter.
// Snapshots one set of channel samples, then emits the frame
//     SYNC_BYTE, SEQ, MASK, LEN, payload..., CHK
// one byte at a time through the transmitter's start/ready handshake.
//
// Ports
//   sclk         system clock
//   rst          synchronous reset, active-high
//   sampleValid  one-cycle strobe qualifying sampleData / chanEnable
//   sampleData   channel k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   chanEnable   per-channel include mask
//   uartReady    transmitter idle and able to accept a byte
//   dataReady    one-cycle start pulse to the transmitter
//   outByte      byte to transmit, valid while dataReady is high (else 0)
//   frameBusy    high from capture until the last byte completes
//   dropCount    saturating count of samples rejected while busy
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | no frame in flight; next sampleValid is captured
// S_SEND     | byte r_idx pending; start pulse issued when uartReady=1
// S_WAIT_ACK | start pulse issued; waiting for transmitter to go busy
// S_WAIT_DONE| transmitter busy; on ready, next byte or end of frame

module telemetry_framer #(
    parameter int          NUM_CHANNELS = 5,
    parameter int          SAMPLE_WIDTH = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                                 sclk,
    input  logic                                 rst,
    input  logic                                 sampleValid,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sampleData,
    input  logic [NUM_CHANNELS-1:0]              chanEnable,
    input  logic                                 uartReady,
    output logic                                 dataReady,
    output logic [7:0]                           outByte,
    output logic                                 frameBusy,
    output logic [7:0]                           dropCount
);

    localparam int         BYTES_PER = (SAMPLE_WIDTH + 7) / 8;
    localparam logic [1:0] BYTE_TOP  = 2'(BYTES_PER - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SEND      = 2'd1;
    localparam logic [1:0] S_WAIT_ACK  = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]                           r_state;
    logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] r_snap;
    logic [7:0]                           r_mask;
    logic [5:0]                           r_len;
    logic [5:0]                           r_idx;
    logic [7:0]                           r_seq;
    logic [7:0]                           r_chk;
    logic [7:0]                           r_drop;
    logic [2:0]                           r_chan;   // channel feeding the payload
    logic [1:0]                           r_bsel;   // byte of that sample, MSB first

    logic [7:0]  w_mask_in;
    logic [5:0]  w_len_in;
    logic [31:0] w_sample;
    logic [7:0]  w_pay_byte;
    logic [7:0]  w_byte;
    logic        w_last;
    logic        w_is_pay;
    logic [2:0]  w_next_chan;

    function automatic logic [3:0] popcnt(input logic [7:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int k = 0; k < 8; k++) begin
            c = c + {3'd0, m[k]};
        end
        return c;
    endfunction

    // Lowest enabled channel index >= start; 0 when none (never used then).
    function automatic logic [2:0] first_from(input logic [7:0] m, input logic [3:0] start);
        logic [2:0] res;
        logic       found;
        res   = 3'd0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!found && (4'(k) >= start) && m[k]) begin
                res   = 3'(k);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_mask_in                     = 8'd0;
        w_mask_in[NUM_CHANNELS-1:0]   = chanEnable;
        w_len_in                      = 6'(int'(popcnt(w_mask_in)) * BYTES_PER);
    end

    // Payload byte: current channel's sample, zero-extended, byte r_bsel.
    always_comb begin
        w_sample = 32'd0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (3'(k) == r_chan) begin
                w_sample[SAMPLE_WIDTH-1:0] = r_snap[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            end
        end
        case (r_bsel)
            2'd0:    w_pay_byte = w_sample[7:0];
            2'd1:    w_pay_byte = w_sample[15:8];
            2'd2:    w_pay_byte = w_sample[23:16];
            default: w_pay_byte = w_sample[31:24];
        endcase
    end

    assign w_last      = (r_idx == 6'd4 + r_len);
    assign w_is_pay    = (r_idx >= 6'd4) && (r_idx < 6'd4 + r_len);
    assign w_next_chan = first_from(r_mask, {1'b0, r_chan} + 4'd1);

    always_comb begin
        case (r_idx)
            6'd0:    w_byte = SYNC_BYTE;
            6'd1:    w_byte = r_seq;
            6'd2:    w_byte = r_mask;
            6'd3:    w_byte = {2'b00, r_len};
            default: w_byte = w_last ? r_chk : w_pay_byte;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_snap  <= '0;
            r_mask  <= 8'd0;
            r_len   <= 6'd0;
            r_idx   <= 6'd0;
            r_seq   <= 8'd0;
            r_chk   <= 8'd0;
            r_drop  <= 8'd0;
            r_chan  <= 3'd0;
            r_bsel  <= BYTE_TOP;
        end else begin
            if (sampleValid && (r_state != S_IDLE) && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (sampleValid) begin
                        r_snap  <= sampleData;
                        r_mask  <= w_mask_in;
                        r_len   <= w_len_in;
                        r_idx   <= 6'd0;
                        r_chk   <= 8'd0;
                        r_chan  <= first_from(w_mask_in, 4'd0);
                        r_bsel  <= BYTE_TOP;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (uartReady) begin
                        // Checksum covers everything after SYNC up to CHK itself.
                        if ((r_idx != 6'd0) && !w_last) begin
                            r_chk <= r_chk ^ w_byte;
                        end
                        r_state <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (!uartReady) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (uartReady) begin
                        if (w_last) begin
                            r_seq   <= r_seq + 8'd1;
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= S_SEND;
                            if (w_is_pay) begin
                                if (r_bsel == 2'd0) begin
                                    r_chan <= w_next_chan;
                                    r_bsel <= BYTE_TOP;
                                end else begin
                                    r_bsel <= r_bsel - 2'd1;
                                end
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Start pulse is combinational on uartReady so the first byte can go out
    // in the cycle right after capture.
    assign dataReady = (r_state == S_SEND) && uartReady;
    assign outByte   = dataReady ? w_byte : 8'h00;
    assign frameBusy = (r_state != S_IDLE);
    assign dropCount = r_drop;

endmodule
